// File: rtl/mdu_hilo.sv
// mdu_hilo: EX-stage multiply/divide unit that owns the architectural HI/LO
// registers.
//
// MULT/MULTU/DIV/DIVU compute their full result in the cycle they are
// accepted and hold it in hi_tmp/lo_tmp. The result is committed to HI/LO
// only after a fixed latency. MTHI/MTLO write HI/LO in a single cycle.
//
// Ports:
//   clk    - clock; all state changes on posedge
//   rst    - asynchronous active-low reset
//   start  - one-cycle request qualifier for op
//   op     - 0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO (6,7 reserved)
//   A, B   - rs / rt operands (forwarded register-file reads)
//   busy   - registered; high while a mult/div is in flight
//   HI, LO - architectural HI/LO registers
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
    // Clear for divide-by-zero, so that completion leaves HI/LO untouched.
    logic          wr_q, wr_d;

    // ---------------- arithmetic ----------------
    logic [63:0] prod_s, prod_u;
    logic [31:0] a_mag, b_mag, b_u_safe, b_m_safe;
    logic [31:0] q_u, r_u, q_m, r_m, q_s, r_s;

    always_comb begin
        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'd0, A} * {32'd0, B};

        // Signed divide is done on magnitudes, then the signs are fixed up:
        // the quotient truncates toward zero and the remainder takes the
        // dividend's sign. 0x80000000 / -1 falls out naturally as 0x80000000.
        a_mag    = A[31] ? (32'd0 - A) : A;
        b_mag    = B[31] ? (32'd0 - B) : B;
        // A zero divisor is replaced by 1 only to keep the datapath defined;
        // the result is discarded through wr_q in that case.
        b_u_safe = (B == 32'd0) ? 32'd1 : B;
        b_m_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;

        q_u = A / b_u_safe;
        r_u = A % b_u_safe;
        q_m = a_mag / b_m_safe;
        r_m = a_mag % b_m_safe;
        q_s = (A[31] ^ B[31]) ? (32'd0 - q_m) : q_m;
        r_s = A[31] ? (32'd0 - r_m) : r_m;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        wr_d     = wr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'd0: begin
                            hi_tmp_d = prod_s[63:32];
                            lo_tmp_d = prod_s[31:0];
                            cnt_d    = CW'(MULT_CYCLES);
                            wr_d     = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = RUN;
                        end
                        3'd1: begin
                            hi_tmp_d = prod_u[63:32];
                            lo_tmp_d = prod_u[31:0];
                            cnt_d    = CW'(MULT_CYCLES);
                            wr_d     = 1'b1;
                            busy_d   = 1'b1;
                            state_d  = RUN;
                        end
                        3'd2: begin
                            hi_tmp_d = r_s;
                            lo_tmp_d = q_s;
                            cnt_d    = CW'(DIV_CYCLES);
                            wr_d     = (B != 32'd0);
                            busy_d   = 1'b1;
                            state_d  = RUN;
                        end
                        3'd3: begin
                            hi_tmp_d = r_u;
                            lo_tmp_d = q_u;
                            cnt_d    = CW'(DIV_CYCLES);
                            wr_d     = (B != 32'd0);
                            busy_d   = 1'b1;
                            state_d  = RUN;
                        end
                        3'd4:    hi_d = A;
                        3'd5:    lo_d = A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // start is ignored here; the hazard unit is stalling on busy.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                    if (wr_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            wr_q     <= wr_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo. Stimulus pushes the expected commit of each mult/div
// (result, busy length, HI/LO that must be held meanwhile) into a queue; a
// negedge monitor measures busy, checks HI/LO are held while busy and
// compares the result when busy falls. Single-cycle ops (MTHI/MTLO,
// reserved ops, reset) are checked directly by the stimulus.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] phi;
        logic [31:0] plo;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          bcnt   = 0;
    logic [31:0] exp_hi = 0;
    logic [31:0] exp_lo = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t it;
        if (!rst) begin
            bcnt = 0;
        end else if (busy) begin
            bcnt++;
            if (q.size() == 0) begin
                chk("busy_unexpected", {31'd0, busy}, 32'd0);
            end else begin
                chk("hold_hi", HI, q[0].phi);
                chk("hold_lo", LO, q[0].plo);
            end
        end else if (bcnt > 0) begin
            if (q.size() == 0) begin
                chk("commit_unexpected", 32'(bcnt), 32'd0);
            end else begin
                it = q.pop_front();
                chk("busy_cycles", 32'(bcnt), 32'(it.cyc));
                chk("result_hi", HI, it.hi);
                chk("result_lo", LO, it.lo);
            end
            bcnt = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int cyc, input logic [31:0] ehi, input logic [31:0] elo);
        exp_t it;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        if (o < 3'd4) begin
            it.hi = ehi; it.lo = elo; it.phi = exp_hi; it.plo = exp_lo; it.cyc = cyc;
            q.push_back(it);
            exp_hi = ehi;
            exp_lo = elo;
        end else if (o == 3'd4) begin
            exp_hi = a;
        end else if (o == 3'd5) begin
            exp_lo = a;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) return;
        end
        chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = 3'd0; A = 0; B = 0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // MTHI then MTLO on consecutive edges
        @(negedge clk);
        start = 1'b1; op = 3'd4; A = 32'hDEADBEEF;
        @(negedge clk);
        chk("mthi_hi", HI, 32'hDEADBEEF);
        chk("mthi_lo", LO, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        op = 3'd5; A = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_hi", HI, 32'hDEADBEEF);
        chk("mtlo_lo", LO, 32'h12345678);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        exp_hi = 32'hDEADBEEF;
        exp_lo = 32'h12345678;

        // reset in the middle of a DIV (counter at 4)
        issue(3'd2, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        q.delete();
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        exp_hi = 0; exp_lo = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (14) @(negedge clk);
        chk("postrst_hi", HI, 32'd0);
        chk("postrst_lo", LO, 32'd0);
        chk("postrst_busy", {31'd0, busy}, 32'd0);

        // multiplies
        issue(3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        wait_done("mult");
        issue(3'd1, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
        wait_done("multu");

        // divides
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        wait_done("div");
        issue(3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        wait_done("divu");
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
        wait_done("div_ovf");

        // divide by zero leaves preloaded HI/LO alone
        issue(3'd4, 32'h11, 32'd0, 0, 32'd0, 32'd0);
        issue(3'd5, 32'h22, 32'd0, 0, 32'd0, 32'd0);
        chk("pre_dz_hi", HI, 32'h11);
        chk("pre_dz_lo", LO, 32'h22);
        issue(3'd2, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        wait_done("div0");
        issue(3'd3, 32'hFFFFFFFF, 32'd0, 10, 32'h11, 32'h22);
        wait_done("divu0");

        // starts during RUN are ignored
        issue(3'd0, 32'd6, 32'd7, 5, 32'd0, 32'h2A);
        @(negedge clk);
        start = 1'b1; op = 3'd5; A = 32'h00000BAD;
        @(negedge clk);
        op = 3'd2; A = 32'd100; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done("inrun");
        repeat (12) @(negedge clk);
        chk("inrun_hi", HI, 32'd0);
        chk("inrun_lo", LO, 32'h2A);

        // reserved ops do nothing
        @(negedge clk);
        start = 1'b1; op = 3'd6; A = 32'h55; B = 32'h66;
        @(negedge clk);
        op = 3'd7;
        @(negedge clk);
        start = 1'b0;
        chk("rsv_busy", {31'd0, busy}, 32'd0);
        chk("rsv_hi", HI, 32'd0);
        chk("rsv_lo", LO, 32'h2A);

        repeat (3) @(negedge clk);
        if (q.size() != 0) chk("queue_left", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
